// File: rtl/visited_tas_responder.sv
// Visited-set responder: one bit per vertex in word-wide RAM, answered with
// the prior bit and optionally set in a 2-stage read-modify-write pipeline.
module visited_tas_responder #(
  parameter int unsigned INDEX_BITS = 10,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned PROC_BITS  = 0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [31:0]           v_addr_in,
  input  logic                  v_addr_valid_in,
  input  logic                  set_in,
  input  logic                  clear_in,
  output logic                  ready_out,
  output logic                  visited_out,
  output logic                  valid_v_out,
  output logic [INDEX_BITS:0]   count_out
);

  localparam int unsigned BIT_BITS  = $clog2(WORD_WIDTH);
  localparam int unsigned WORD_BITS = INDEX_BITS - BIT_BITS;
  localparam int unsigned WA        = (WORD_BITS > 0) ? WORD_BITS : 1;
  localparam int unsigned NUM_WORDS = (2 ** INDEX_BITS) / WORD_WIDTH;
  localparam int unsigned CW        = INDEX_BITS + 1;

  typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_DRAIN} state_e;

  state_e                  state_q;
  logic [WA-1:0]           ptr_q;
  logic                    ready_q;
  logic                    visited_q;
  logic                    valid_q;
  logic [CW-1:0]           count_q;

  logic                    s1_valid_q;
  logic                    s1_set_q;
  logic [WA-1:0]           s1_word_q;
  logic [BIT_BITS-1:0]     s1_bit_q;
  logic                    s1_byp_q;
  logic [WORD_WIDTH-1:0]   s1_byp_data_q;

  logic                    s2_valid_q;
  logic                    s2_set_q;
  logic [WA-1:0]           s2_word_q;
  logic [WORD_WIDTH-1:0]   s2_data_q;

  logic [WORD_WIDTH-1:0]   mem_q [NUM_WORDS];
  logic [WORD_WIDTH-1:0]   rdata_q;

  logic [INDEX_BITS-1:0]   s0_idx_d;
  logic [WA-1:0]           s0_word_d;
  logic [BIT_BITS-1:0]     s0_bit_d;
  logic                    accept_d;
  logic                    s0_hit_d;
  logic                    s2_fwd_d;
  logic [WORD_WIDTH-1:0]   s1_data_d;
  logic [WORD_WIDTH-1:0]   s1_new_d;
  logic                    old_d;
  logic                    we_d;
  logic [WA-1:0]           waddr_d;
  logic [WORD_WIDTH-1:0]   wdata_d;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^v_addr_in;
  assign s0_idx_d  = v_addr_in[PROC_BITS +: INDEX_BITS];
  assign s0_word_d = WA'(s0_idx_d >> BIT_BITS);
  assign s0_bit_d  = s0_idx_d[BIT_BITS-1:0];

  assign ready_out   = ready_q;
  assign visited_out = visited_q;
  assign valid_v_out = valid_q;
  assign count_out   = count_q;

  // S1 word selection: newest in-flight write to the same word wins over RAM data
  always_comb begin
    accept_d  = v_addr_valid_in && ready_q && !clear_in;
    s0_hit_d  = s2_valid_q && s2_set_q && (s2_word_q == s0_word_d);
    s2_fwd_d  = s2_valid_q && s2_set_q && (s2_word_q == s1_word_q);
    s1_data_d = rdata_q;
    if (s1_byp_q) s1_data_d = s1_byp_data_q;
    if (s2_fwd_d) s1_data_d = s2_data_q;
    old_d     = s1_data_d[s1_bit_q];
    s1_new_d  = s1_data_d;
    if (s1_set_q) s1_new_d = s1_data_d | (WORD_WIDTH'(1) << s1_bit_q);

    we_d    = 1'b0;
    waddr_d = s2_word_q;
    wdata_d = s2_data_q;
    if (!rst_in) begin
      we_d = 1'b0;
    end else if (state_q == ST_CLEAR) begin
      we_d    = 1'b1;
      waddr_d = ptr_q;
      wdata_d = '0;
    end else if (s2_valid_q && s2_set_q) begin
      we_d = 1'b1;
    end
  end

  // Single-port-write, synchronous-read visited RAM (contents not reset)
  always_ff @(posedge clk_in) begin
    if (we_d) mem_q[waddr_d] <= wdata_d;
    rdata_q <= mem_q[s0_word_d];
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q       <= ST_CLEAR;
      ptr_q         <= '0;
      ready_q       <= 1'b0;
      visited_q     <= 1'b0;
      valid_q       <= 1'b0;
      count_q       <= '0;
      s1_valid_q    <= 1'b0;
      s1_set_q      <= 1'b0;
      s1_word_q     <= '0;
      s1_bit_q      <= '0;
      s1_byp_q      <= 1'b0;
      s1_byp_data_q <= '0;
      s2_valid_q    <= 1'b0;
      s2_set_q      <= 1'b0;
      s2_word_q     <= '0;
      s2_data_q     <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          ptr_q <= ptr_q + WA'(1);
          if (ptr_q == WA'(NUM_WORDS - 1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (clear_in) begin
            state_q <= ST_DRAIN;
            ready_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // Sweep only once the last pending write has reached RAM
          if (!s1_valid_q && !s2_valid_q) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          ptr_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase

      s1_valid_q    <= accept_d;
      s1_set_q      <= set_in;
      s1_word_q     <= s0_word_d;
      s1_bit_q      <= s0_bit_d;
      s1_byp_q      <= s0_hit_d;
      s1_byp_data_q <= s2_data_q;

      s2_valid_q <= s1_valid_q;
      s2_set_q   <= s1_set_q;
      s2_word_q  <= s1_word_q;
      s2_data_q  <= s1_new_d;

      valid_q <= s1_valid_q;
      if (s1_valid_q) visited_q <= old_d;

      if (state_q == ST_CLEAR) begin
        count_q <= '0;
      end else if (s1_valid_q && s1_set_q && !old_d) begin
        count_q <= count_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_visited_tas_responder.sv
// Scoreboard bench for visited_tas_responder with a 64-vertex, 8-bit-word set.
module tb_visited_tas_responder;

  localparam int unsigned INDEX_BITS = 6;
  localparam int unsigned WORD_WIDTH = 8;
  localparam int unsigned PROC_BITS  = 0;

  logic                clk_in = 1'b0;
  logic                rst_in = 1'b0;
  logic [31:0]         v_addr_in = '0;
  logic                v_addr_valid_in = 1'b0;
  logic                set_in = 1'b0;
  logic                clear_in = 1'b0;
  logic                ready_out;
  logic                visited_out;
  logic                valid_v_out;
  logic [INDEX_BITS:0] count_out;

  typedef struct {
    logic vis;
    int   cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic ref_vis [64];
  int   ref_count;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   low;

  visited_tas_responder #(
    .INDEX_BITS(INDEX_BITS),
    .WORD_WIDTH(WORD_WIDTH),
    .PROC_BITS (PROC_BITS)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .v_addr_in      (v_addr_in),
    .v_addr_valid_in(v_addr_valid_in),
    .set_in         (set_in),
    .clear_in       (clear_in),
    .ready_out      (ready_out),
    .visited_out    (visited_out),
    .valid_v_out    (valid_v_out),
    .count_out      (count_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response monitor: every strobe must match the oldest outstanding expectation
  always @(negedge clk_in) begin
    if (valid_v_out) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", int'(valid_v_out), 0);
      end else begin
        mon_e = sb.pop_front();
        check("resp_visited", int'(visited_out), int'(mon_e.vis));
        check("resp_latency", cyc, mon_e.cyc);
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 64; i++) ref_vis[i] = 1'b0;
    ref_count = 0;
  endtask

  // Entered and left on a negedge
  task automatic req(input int addr, input logic set, input logic accepted);
    int idx;
    exp_t e;
    idx = addr % 64;
    v_addr_in       = 32'(addr);
    v_addr_valid_in = 1'b1;
    set_in          = set;
    if (accepted) begin
      e.vis = ref_vis[idx];
      e.cyc = cyc + 2;
      sb.push_back(e);
      if (set) begin
        if (!ref_vis[idx]) ref_count++;
        ref_vis[idx] = 1'b1;
      end
    end
    @(negedge clk_in);
    v_addr_valid_in = 1'b0;
    set_in          = 1'b0;
  endtask

  task automatic idle(input int n);
    v_addr_valid_in = 1'b0;
    set_in          = 1'b0;
    clear_in        = 1'b0;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic do_reset();
    rst_in          = 1'b0;
    v_addr_valid_in = 1'b0;
    set_in          = 1'b0;
    clear_in        = 1'b0;
    @(posedge clk_in);
    #1;
    sb.delete();
    model_clear();
    @(negedge clk_in);
    check("rst_visited", int'(visited_out), 0);
    check("rst_valid", int'(valid_v_out), 0);
    check("rst_ready", int'(ready_out), 0);
    check("rst_count", int'(count_out), 0);
  endtask

  task automatic release_and_sweep();
    rst_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("sweep_ready_low", int'(ready_out), 0);
      @(negedge clk_in);
    end
    check("sweep_ready_high", int'(ready_out), 1);
    check("sweep_count", int'(count_out), 0);
  endtask

  initial begin
    model_clear();
    repeat (3) @(negedge clk_in);

    // 1: reset and initial clear sweep
    do_reset();
    release_and_sweep();

    // 2: first set, repeated set, alias
    req(5, 1'b1, 1'b1);
    idle(4);
    req(5, 1'b1, 1'b1);
    idle(3);
    check("s2_count", int'(count_out), ref_count);
    req(69, 1'b1, 1'b1);
    idle(3);
    check("s2_count_alias", int'(count_out), ref_count);

    // 3: back-to-back same-word forwarding
    req(9, 1'b1, 1'b1);
    req(9, 1'b1, 1'b1);
    req(10, 1'b1, 1'b1);
    idle(3);
    check("s3_count", int'(count_out), ref_count);

    // 4: queries never mark
    req(20, 1'b0, 1'b1);
    req(20, 1'b0, 1'b1);
    req(20, 1'b1, 1'b1);
    idle(3);
    check("s4_count", int'(count_out), ref_count);
    req(20, 1'b0, 1'b1);
    idle(3);
    check("s4_count_after_query", int'(count_out), ref_count);

    // 5: clear with requests in flight; request with clear and during sweep dropped
    req(1, 1'b1, 1'b1);
    req(2, 1'b1, 1'b1);
    v_addr_in       = 32'd3;
    v_addr_valid_in = 1'b1;
    set_in          = 1'b1;
    clear_in        = 1'b1;
    @(negedge clk_in);
    clear_in        = 1'b0;
    v_addr_valid_in = 1'b0;
    set_in          = 1'b0;
    model_clear();
    low = 0;
    for (int i = 0; i < 30 && !ready_out; i++) begin
      if (low == 4) begin
        v_addr_in       = 32'd7;
        v_addr_valid_in = 1'b1;
        set_in          = 1'b1;
      end else begin
        v_addr_valid_in = 1'b0;
        set_in          = 1'b0;
      end
      low++;
      @(negedge clk_in);
    end
    v_addr_valid_in = 1'b0;
    set_in          = 1'b0;
    check("s5_ready_back", int'(ready_out), 1);
    check("s5_low_len_ok", int'(low >= 8 && low <= 10), 1);
    check("s5_count_cleared", int'(count_out), 0);
    req(5, 1'b1, 1'b1);
    req(7, 1'b0, 1'b1);
    req(3, 1'b0, 1'b1);
    idle(3);
    check("s5_count", int'(count_out), ref_count);

    // 6a: reset in the middle of a clear sweep
    do_reset();
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check("s6_mid_sweep_ready", int'(ready_out), 0);
    do_reset();
    release_and_sweep();

    // 6b: reset with requests in flight
    req(11, 1'b1, 1'b1);
    idle(3);
    req(11, 1'b1, 1'b1);
    req(12, 1'b1, 1'b1);
    do_reset();
    idle(4);
    release_and_sweep();
    req(11, 1'b0, 1'b1);
    req(12, 1'b0, 1'b1);
    req(5, 1'b1, 1'b1);
    idle(4);
    check("s6_count", int'(count_out), ref_count);
    check("queue_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/visited_tas_responder.md
Name: visited_tas_responder

Overview:
- Responder end of the visited-set request/response protocol issued by graph_fetch during greedy graph search.
- Holds one visited bit per vertex in word-organised block RAM and answers each lookup with the vertex's prior visited value.
- Optionally marks the vertex visited atomically, as a pipelined read-modify-write (test-and-set).
- Provides a hardware clear sweep so that successive queries start from an empty visited set without reloading memory.

Parameters:
- INDEX_BITS, 10, log2 of vertex capacity; vertex index = v_addr_in[PROC_BITS +: INDEX_BITS].
- WORD_WIDTH, 32, visited bits per RAM word (power of two, at most 2^INDEX_BITS); NUM_WORDS = 2^INDEX_BITS / WORD_WIDTH.
- PROC_BITS, 0, low address bits ignored (per-processor interleave); matches graph_memory/visited usage.

Ports:
- clk_in  input  1  single clock.
- rst_in  input  1  synchronous, active-low reset (0 = reset).
- v_addr_in  input  32  vertex address of the request.
- v_addr_valid_in  input  1  request strobe, one request per cycle.
- set_in  input  1  sampled with the request; 1 = test-and-set, 0 = query only.
- clear_in  input  1  single-cycle pulse that starts a clear of the whole set.
- ready_out  output  1  high when requests and clear_in are accepted.
- visited_out  output  1  prior visited bit of the responded request.
- valid_v_out  output  1  response strobe, one cycle per accepted request.
- count_out  output  INDEX_BITS+1  distinct vertices marked since the last clear.

Behaviour:
- Reset (rst_in=0 at a clock edge):
  - Next cycle: visited_out=0, valid_v_out=0, ready_out=0, count_out=0.
  - All in-flight requests are discarded, with no response.
  - FSM enters CLEAR (word pointer=0). RAM contents are never assumed valid after reset.
- FSM states:
  - CLEAR: write zero to word[ptr], ptr++. After the NUM_WORDS-th write, go to RUN with ready_out=1 and count_out=0.
  - RUN: ready_out=1. clear_in=1 goes to DRAIN and drops ready_out the next cycle.
  - DRAIN: ready_out=0. Wait until pipeline stages S1/S2 are empty (at most 2 cycles), then go to CLEAR.
- Acceptance: a request is accepted iff v_addr_valid_in=1 and ready_out=1 in the same cycle. Requests while ready_out=0 are dropped silently.
  - clear_in and v_addr_valid_in together in RUN: the clear is taken and the request is dropped.
  - clear_in outside RUN is ignored.
- Pipeline, fixed latency 2, throughput 1/cycle:
  - S0, accept cycle T: index split into word = idx[INDEX_BITS-1:log2 WORD_WIDTH] and bit = idx[log2 WORD_WIDTH-1:0]; synchronous RAM read issued.
  - S1, T+1: read data registered.
  - S2, T+2: old = word_data[bit]. Drive visited_out=old and valid_v_out=1. If set_in=1, write word_data with bit set.
- Ordering and hazards:
  - Responses return in request order, and each reflects every earlier accepted set.
  - If a request reads a word that an older in-flight request (S1 or S2, same or previous cycle) writes, the newer updated word is forwarded in place of the RAM read data.
  - Back-to-back requests to the same vertex: the second returns 1 if the first was a set.
- count_out increments by 1 at S2 when set_in=1 and old=0. It cannot overflow because it is at most 2^INDEX_BITS.
- Address bits above PROC_BITS+INDEX_BITS are ignored, so aliasing is intended.
- Query-only requests (set_in=0) never write RAM and never change count_out.
- valid_v_out is 0 in every cycle without a completing request, and visited_out holds its last value.

Test Plan (INDEX_BITS=6, WORD_WIDTH=8, PROC_BITS=0 → NUM_WORDS=8):
1. Release rst_in at T0 → ready_out=0 for cycles T0..T0+7, ready_out=1 from T0+8; count_out=0; valid_v_out never asserted.
2. Set request addr 5 at cycle T → at T+2 valid_v_out=1, visited_out=0. Same request at T+5 → visited_out=1. count_out=1. Addr 69 (aliases 5) → visited_out=1.
3. Set requests addr 9, 9, 10 in consecutive cycles T..T+2 → responses at T+2..T+4 are 0, 1, 0 (forwarding within word 1); count_out=3.
4. Query (set_in=0) addr 20 twice, then set addr 20 → responses 0, 0, 0; count_out increments only once; next query of addr 20 → 1.
5. After scenario 2, pulse clear_in one cycle after issuing requests addr 1 and addr 2 → both responses still delivered at their T+2 slots, then ready_out=0 for 8 CLEAR cycles. A request driven during ready_out=0 gets no response. Afterwards addr 5 → 0 and count_out=0.
6. Assert rst_in=0 during a CLEAR sweep and again with 2 requests in flight → next cycle all outputs are 0, no stale responses appear, and the full 8-cycle sweep restarts from word 0.
